// File: rtl/mem_store_writer_pkg.sv
// Shared types and helpers for the byte-scatter store writer: size codes,
// FSM states, legality and big-endian lane selection.
package mem_store_writer_pkg;

   localparam int unsigned CPU_WIDTH = 32;
   localparam int unsigned CPU_BYTE  = 8;

   typedef enum logic [1:0] {
      STORE_B = 2'b00,
      STORE_H = 2'b01,
      STORE_W = 2'b10,
      STORE_X = 2'b11
   } store_size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   function automatic logic store_legal(store_size_e size, logic [1:0] addr_lo);
      case (size)
         STORE_B: return 1'b1;
         STORE_H: return ~addr_lo[0];
         STORE_W: return (addr_lo == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Index of the final byte of a store (byte count minus one).
   function automatic logic [1:0] store_last(store_size_e size);
      case (size)
         STORE_B: return 2'd0;
         STORE_H: return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // Byte k of a right-aligned store, most significant byte first.
   function automatic logic [CPU_BYTE-1:0] store_lane(logic [CPU_WIDTH-1:0] data,
                                                      logic [1:0] last,
                                                      logic [1:0] k);
      logic [4:0]           shift;
      logic [CPU_WIDTH-1:0] shifted;
      shift   = {last - k, 3'b000};
      shifted = data >> shift;
      return shifted[CPU_BYTE-1:0];
   endfunction

endpackage

// File: rtl/mem_store_writer_if.sv
// Store-request handshake plus byte-wide memory write port of the store writer.
interface mem_store_writer_if #(
   parameter int unsigned ADDR_W = 6
);
   import mem_store_writer_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic [CPU_WIDTH-1:0]  req_data;
   logic [1:0]            req_size;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [CPU_BYTE-1:0]   mem_wdata;
   logic                  done;
   logic                  err;
   logic                  busy;

   modport master (
      output req_valid, req_addr, req_data, req_size,
      input  req_ready, mem_we, mem_addr, mem_wdata, done, err, busy
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_size,
      output req_ready, mem_we, mem_addr, mem_wdata, done, err, busy
   );

endinterface

// File: rtl/mem_store_writer_fifo.sv
// Synchronous request queue holding packed {addr, data, size} store entries.
module store_req_fifo #(
   parameter int unsigned WIDTH = 40,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok)
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_store_writer.sv
// Queues store requests and scatters each into a byte-wide data memory,
// one byte per cycle, big-endian, with registered write-port outputs.
module mem_store_writer
   import mem_store_writer_pkg::*;
#(
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   mem_store_writer_if.slave   bus
);
   localparam int unsigned ENTRY_W = ADDR_W + CPU_WIDTH + 2;
   localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);

   logic                 push, pop, full, empty, more_after_pop;
   logic [CNT_W-1:0]     count;
   logic [ENTRY_W-1:0]   head;
   logic [ADDR_W-1:0]    head_addr;
   logic [CPU_WIDTH-1:0] head_data;
   store_size_e          head_size;
   logic [1:0]           head_last, cnt_nxt;

   state_e               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d, last_q, last_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [CPU_WIDTH-1:0] data_q, data_d;
   logic                 mem_we_q, mem_we_d, done_q, done_d, err_q, err_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [CPU_BYTE-1:0]  mem_wdata_q, mem_wdata_d;

   assign push = bus.req_valid & ~full;

   store_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.req_addr, bus.req_data, bus.req_size}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign head_addr      = head[ENTRY_W-1 -: ADDR_W];
   assign head_data      = head[2 +: CPU_WIDTH];
   assign head_size      = store_size_e'(head[1:0]);
   assign head_last      = store_last(head_size);
   assign cnt_nxt        = cnt_q + 1'b1;
   // After the CHECK pop the queue is still occupied if it held two or a push lands now.
   assign more_after_pop = (count > CNT_W'(1)) | push;

   // Outputs are registered: each state computes what the port shows next cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      addr_d      = addr_q;
      data_d      = data_q;
      pop         = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty || push) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            pop = 1'b1;
            if (store_legal(head_size, head_addr[1:0])) begin
               state_d     = ST_WRITE;
               addr_d      = head_addr;
               data_d      = head_data;
               last_d      = head_last;
               cnt_d       = 2'd0;
               mem_we_d    = 1'b1;
               mem_addr_d  = head_addr;
               mem_wdata_d = store_lane(head_data, head_last, 2'd0);
               done_d      = (head_last == 2'd0);
            end else begin
               err_d   = 1'b1;
               state_d = more_after_pop ? ST_CHECK : ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (cnt_q == last_q) begin
               state_d = (!empty || push) ? ST_CHECK : ST_IDLE;
            end else begin
               cnt_d       = cnt_nxt;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q + ADDR_W'(cnt_nxt);
               mem_wdata_d = store_lane(data_q, last_q, cnt_nxt);
               done_d      = (cnt_nxt == last_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         last_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.req_ready = ~full;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = ~empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_store_writer.sv
// Scoreboard bench for mem_store_writer: directed stores push expected byte
// writes / error pulses; a negedge monitor pops and compares.
module tb_mem_store_writer;
   import mem_store_writer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_store_writer_if #(.ADDR_W(6)) bus();

   mem_store_writer #(
      .ADDR_W      (6),
      .QUEUE_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] data;
      logic       done;
   } wr_t;

   wr_t exp_q[$];
   int  err_exp = 0;
   int  checks  = 0;
   int  errors  = 0;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_wr(input logic [5:0] a, input logic [7:0] d, input logic dn);
      exp_q.push_back(wr_t'{addr: a, data: d, done: dn});
   endtask

   // Monitor: every write must match the head of the expected queue.
   wr_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_write", {18'd0, bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("wr_addr",  32'(bus.mem_addr),  32'(mon_e.addr));
               check_eq("wr_data",  32'(bus.mem_wdata), 32'(mon_e.data));
               check_eq("wr_done",  32'(bus.done),      32'(mon_e.done));
            end
         end else begin
            check_eq("idle_bus", {23'd0, bus.done, bus.mem_addr, 2'b00} | 32'(bus.mem_wdata), 32'd0);
         end
         if (bus.err) begin
            check_eq("err_pulse_expected", 32'(err_exp > 0), 32'd1);
            if (err_exp > 0) err_exp--;
         end
      end
   end

   task automatic send(input logic [5:0] a, input logic [31:0] d, input logic [1:0] s);
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_data  = d;
      bus.req_size  = s;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("send_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.req_size  = '0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((bus.busy || exp_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq(name, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check_eq({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      check_eq({name, "_pending_errs"}, 32'(err_exp), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [12:0] pat, exp_pat;

   initial begin
      idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_eq("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check_eq("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check_eq("rst_done",      32'(bus.done),      32'd0);
      check_eq("rst_err",       32'(bus.err),       32'd0);
      check_eq("rst_busy",      32'(bus.busy),      32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Word store with latency: CHECK next cycle, first write the cycle after.
      expect_wr(6'h04, 8'h11, 1'b0);
      expect_wr(6'h05, 8'h22, 1'b0);
      expect_wr(6'h06, 8'h33, 1'b0);
      expect_wr(6'h07, 8'h44, 1'b1);
      send(6'h04, 32'h1122_3344, 2'b10);
      idle();
      @(negedge clk);
      check_eq("lat_check_no_we", 32'(bus.mem_we), 32'd0);
      check_eq("lat_check_busy",  32'(bus.busy),   32'd1);
      @(negedge clk);
      check_eq("lat_first_we",    32'(bus.mem_we), 32'd1);
      wait_idle("word");

      // Half and byte stores.
      expect_wr(6'h0A, 8'hBE, 1'b0);
      expect_wr(6'h0B, 8'hEF, 1'b1);
      send(6'h0A, 32'h0000_BEEF, 2'b01);
      idle();
      wait_idle("half");
      expect_wr(6'h3F, 8'h5A, 1'b1);
      send(6'h3F, 32'h0000_005A, 2'b00);
      idle();
      wait_idle("byte");

      // Illegal / misaligned requests: three err pulses, no writes.
      err_exp = 3;
      send(6'h06, 32'hDEAD_BEEF, 2'b10);
      send(6'h03, 32'h0000_1234, 2'b01);
      send(6'h00, 32'h0000_0077, 2'b11);
      idle();
      wait_idle("illegal");

      // Three back-to-back words: queue fills, one CHECK gap between stores.
      expect_wr(6'h20, 8'hA0, 1'b0); expect_wr(6'h21, 8'hA1, 1'b0);
      expect_wr(6'h22, 8'hA2, 1'b0); expect_wr(6'h23, 8'hA3, 1'b1);
      expect_wr(6'h24, 8'hB0, 1'b0); expect_wr(6'h25, 8'hB1, 1'b0);
      expect_wr(6'h26, 8'hB2, 1'b0); expect_wr(6'h27, 8'hB3, 1'b1);
      expect_wr(6'h28, 8'hC0, 1'b0); expect_wr(6'h29, 8'hC1, 1'b0);
      expect_wr(6'h2A, 8'hC2, 1'b0); expect_wr(6'h2B, 8'hC3, 1'b1);
      send(6'h20, 32'hA0A1_A2A3, 2'b10);
      send(6'h24, 32'hB0B1_B2B3, 2'b10);
      send(6'h28, 32'hC0C1_C2C3, 2'b10);
      check_eq("burst_ready_full", 32'(bus.req_ready), 32'd0);
      idle();
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         pat[i]     = bus.mem_we;
         exp_pat[i] = !(i == 3 || i == 8);
      end
      check_eq("burst_we_pattern", 32'(pat), 32'(exp_pat));
      wait_idle("burst");

      // Push while the head pops: count holds at 1, both stores complete.
      expect_wr(6'h30, 8'h01, 1'b1);
      expect_wr(6'h32, 8'h23, 1'b0);
      expect_wr(6'h33, 8'h45, 1'b1);
      send(6'h30, 32'h0000_0001, 2'b00);
      send(6'h32, 32'h0000_2345, 2'b01);
      check_eq("pushpop_ready", 32'(bus.req_ready), 32'd1);
      check_eq("pushpop_busy",  32'(bus.busy),      32'd1);
      idle();
      wait_idle("pushpop");

      // Reset after the second byte of a word: only 10/11 land.
      expect_wr(6'h10, 8'hAA, 1'b0);
      expect_wr(6'h11, 8'hBB, 1'b0);
      send(6'h10, 32'hAABB_CCDD, 2'b10);
      idle();
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(bus.mem_we && bus.mem_addr == 6'h11) && n < 20);
         check_eq("rst_mid_seen_11", 32'(bus.mem_addr), 32'h11);
      end
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_mid_we",    32'(bus.mem_we), 32'd0);
      check_eq("rst_mid_busy",  32'(bus.busy),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      check_eq("rst_mid_busy2", 32'(bus.busy),      32'd0);
      repeat (6) @(negedge clk);
      check_eq("rst_mid_queue", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
